// File: rtl/d_e_pipe_reg.sv
// Decode/Execute pipeline register: carries the decoded bundle from D to E,
// inserting bubbles on stall and flushing to the handler PC on exception request.
module d_e_pipe_reg #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        stall,
    input  logic [31:0] D_PC,
    input  logic [31:0] D_Instr,
    input  logic [31:0] D_RS_Data,
    input  logic [31:0] D_RT_Data,
    input  logic [31:0] D_Ext,
    input  logic [4:0]  D_Rs,
    input  logic [4:0]  D_Rt,
    input  logic [4:0]  D_Rd,
    input  logic [1:0]  D_RegDst,
    input  logic [15:0] D_Ctrl,
    input  logic [1:0]  D_Tnew,
    input  logic [4:0]  D_ExcCode,
    input  logic        D_BD,
    output logic [31:0] E_PC,
    output logic [31:0] E_Instr,
    output logic [31:0] E_RS_Data,
    output logic [31:0] E_RT_Data,
    output logic [31:0] E_Ext,
    output logic [4:0]  E_Rs,
    output logic [4:0]  E_Rt,
    output logic [4:0]  E_Rd,
    output logic [1:0]  E_RegDst,
    output logic [15:0] E_Ctrl,
    output logic [1:0]  E_Tnew,
    output logic [4:0]  E_ExcCode,
    output logic        E_BD,
    output logic        E_Valid
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [1:0]  regdst;
        logic [15:0] ctrl;
        logic [1:0]  tnew;
        logic [4:0]  exccode;
        logic        bd;
        logic        valid;
    } de_t;

    de_t e_d;
    de_t e_q;

    always_comb begin
        e_d = '0;
        if (req) begin
            e_d.pc = HANDLER_PC;
        end else if (stall) begin
            // Bubble keeps PC/BD so an interrupt landing on it still gets a correct EPC
            e_d.pc = D_PC;
            e_d.bd = D_BD;
        end else begin
            e_d.pc      = D_PC;
            e_d.instr   = D_Instr;
            e_d.rs_data = D_RS_Data;
            e_d.rt_data = D_RT_Data;
            e_d.ext     = D_Ext;
            e_d.rs      = D_Rs;
            e_d.rt      = D_Rt;
            e_d.rd      = D_Rd;
            e_d.regdst  = D_RegDst;
            e_d.ctrl    = D_Ctrl;
            e_d.tnew    = D_Tnew;
            e_d.exccode = D_ExcCode;
            e_d.bd      = D_BD;
            e_d.valid   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= '0;
            e_q.pc <= RESET_PC;
        end else begin
            e_q <= e_d;
        end
    end

    assign E_PC      = e_q.pc;
    assign E_Instr   = e_q.instr;
    assign E_RS_Data = e_q.rs_data;
    assign E_RT_Data = e_q.rt_data;
    assign E_Ext     = e_q.ext;
    assign E_Rs      = e_q.rs;
    assign E_Rt      = e_q.rt;
    assign E_Rd      = e_q.rd;
    assign E_RegDst  = e_q.regdst;
    assign E_Ctrl    = e_q.ctrl;
    assign E_Tnew    = e_q.tnew;
    assign E_ExcCode = e_q.exccode;
    assign E_BD      = e_q.bd;
    assign E_Valid   = e_q.valid;

endmodule
